serving_ram_arbiter: RTL and testbench
======================================

// Module: serving_ram_arbiter
// PURPOSE
//   Shares the single byte-wide serving_ram between the 32-bit instruction bus (read-only) and the
//   32-bit data bus (read/write with byte selects). It grants one requester at a time and splits
//   each word access into four sequential byte accesses on the RAM port. It assembles read bytes
//   into a word and returns a single-cycle ack. Sits between the CPU bus ports and serving_ram.
// PARAMETERS
//   DEPTH  256             RAM depth in bytes
//   AW     $clog2(DEPTH)   byte address width of the RAM and both bus ports
// PORTS
//   i_clk         in   1   system clock, all state on rising edge
//   i_rst_n       in   1   asynchronous active-low reset
//   i_ibus_adr    in   AW  ibus byte address; bits [1:0] ignored (word aligned)
//   i_ibus_cyc    in   1   ibus request
//   o_ibus_rdt    out  32  ibus read data, valid while o_ibus_ack=1
//   o_ibus_ack    out  1   ibus completion, one-cycle pulse
//   i_dbus_adr    in   AW  dbus byte address; bits [1:0] ignored
//   i_dbus_dat    in   32  dbus write data, byte n = bits [8n+7:8n]
//   i_dbus_sel    in   4   dbus byte enables for writes
//   i_dbus_we     in   1   1=write, 0=read
//   i_dbus_cyc    in   1   dbus request
//   o_dbus_rdt    out  32  dbus read data, valid while o_dbus_ack=1
//   o_dbus_ack    out  1   dbus completion, one-cycle pulse
//   o_ram_waddr   out  AW  RAM write address
//   o_ram_wdata   out  8   RAM write data
//   o_ram_wen     out  1   RAM write enable
//   o_ram_raddr   out  AW  RAM read address
//   o_ram_ren     out  1   RAM read enable
//   i_ram_rdata   in   8   RAM read data
//   i_ram_ack     in   1   RAM read-data-valid (one cycle after ren)
// BEHAVIOUR
// - Reset (async, i_rst_n=0): state=IDLE, byte counter=0, all outputs 0 (both rdt regs cleared).
// - States: IDLE, WR, RD_ISSUE, RD_WAIT, DONE.
// - IDLE: sample both cyc. If either is high, grant one (see CONFIGURATION). Latch adr[AW-1:2], dat,
//   sel and we from the granted bus, clear cnt, and go to WR (dbus with we=1) or RD_ISSUE.
//   No request: stay in IDLE.
// - WR (dbus only), 4 cycles, cnt=0..3: waddr={adr[AW-1:2],cnt[1:0]}, wdata=dat[8cnt+:8],
//   wen=sel[cnt]. Bytes with sel=0 still use a cycle (wen=0). cnt++ each cycle; after cnt=3 go to DONE.
// - RD_ISSUE: ren=1 for exactly one cycle, raddr={adr[AW-1:2],cnt}, then go to RD_WAIT.
// - RD_WAIT: ren=0. On i_ram_ack, store i_ram_rdata into rdt[8cnt+:8] of the granted bus.
//   If cnt=3 go to DONE, else cnt++ and go to RD_ISSUE. Waits indefinitely without ack.
// - DONE: the granted bus ack=1 for exactly this cycle, then IDLE. rdt holds its value until that
//   bus's next read overwrites it.
// - Latency from cyc sampled in IDLE to ack: write=6 cycles (IDLE+4 WR+DONE). Read=10 cycles when
//   ram ack arrives 1 cycle after ren.
// - At most one RAM strobe (wen or ren) high in any cycle. Never both.
// - Requesters hold adr/dat/sel/we stable until ack. Values are latched, so later changes are ignored.
// - cyc dropped mid-transaction: the transaction still completes and ack still pulses.
// - Requester re-asserting cyc right after its ack is re-sampled in the next IDLE. There is no
//   back-to-back grant without an IDLE cycle.
// - i_ram_ack outside RD_WAIT is ignored.
// - Reset mid-transaction: strobes drop immediately. Bytes already written stay written, no ack is
//   issued, and the transaction is lost.
// CONFIGURATION
// - SERVING_ARB_RR_EN defined: round-robin. A last-granted flag (reset=ibus, so dbus wins first
//   contention) is updated at each grant. On simultaneous cyc, the bus not granted last wins.
//   A single requester is always granted.
// - Undefined: fixed priority. dbus always wins simultaneous cyc; ibus may starve under constant
//   dbus traffic.
// TESTING
// 1 Reset: hold i_rst_n=0 with random inputs -> all outputs 0. Release with cyc=0 -> stays idle,
//   strobes 0.
// 2 dbus write adr=0x10 dat=0xDEADBEEF sel=4'hF -> wen on 4 consecutive cycles writing
//   EF@10,BE@11,AD@12,DE@13. o_dbus_ack pulses once, 6 cycles after cyc sampled.
// 3 dbus write adr=0x12 (low bits ignored) dat=0x11223344 sel=4'b0101 -> wen only for 0x10 and 0x12.
//   RAM bytes 0x10..0x13 become 44,BE,22,DE.
// 4 ibus read adr=0x10 -> 4 single-cycle ren pulses at 0x10..0x13. o_ibus_rdt=0xDE22BE44 with
//   ack, 10 cycles after sample. dbus signals untouched.
// 5 Both cyc held high for 4 transactions: without macro all go to dbus first. With
//   SERVING_ARB_RR_EN grants alternate dbus,ibus,dbus,ibus.
// 6 Pull i_rst_n low during WR cnt=2 of the test-2 write over zeroed RAM -> outputs 0 at once.
//   Bytes 0x10,0x11 written, 0x12,0x13 still 00, no ack.

Source files
------------

// File: rtl/serving_ram_arbiter.sv
// rtl/serving_ram_arbiter.sv - arbitrates ibus/dbus word accesses onto the byte-wide serving_ram port
// Optional: SERVING_ARB_RR_EN selects round-robin grant; fixed dbus priority otherwise.
module serving_ram_arbiter #(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic [AW-1:0] i_ibus_adr,
    input  logic          i_ibus_cyc,
    output logic [31:0]   o_ibus_rdt,
    output logic          o_ibus_ack,
    input  logic [AW-1:0] i_dbus_adr,
    input  logic [31:0]   i_dbus_dat,
    input  logic [3:0]    i_dbus_sel,
    input  logic          i_dbus_we,
    input  logic          i_dbus_cyc,
    output logic [31:0]   o_dbus_rdt,
    output logic          o_dbus_ack,
    output logic [AW-1:0] o_ram_waddr,
    output logic [7:0]    o_ram_wdata,
    output logic          o_ram_wen,
    output logic [AW-1:0] o_ram_raddr,
    output logic          o_ram_ren,
    input  logic [7:0]    i_ram_rdata,
    input  logic          i_ram_ack
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_RD_ISSUE,
        S_RD_WAIT,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [AW-3:0] adr_q, adr_d;
    logic [31:0]   dat_q, dat_d;
    logic [3:0]    sel_q, sel_d;
    logic          gnt_dbus_q, gnt_dbus_d;
    logic [31:0]   ibus_rdt_q, ibus_rdt_d;
    logic [31:0]   dbus_rdt_q, dbus_rdt_d;
    logic          ibus_ack_q, ibus_ack_d;
    logic          dbus_ack_q, dbus_ack_d;
    logic [AW-1:0] ram_waddr_q, ram_waddr_d;
    logic [7:0]    ram_wdata_q, ram_wdata_d;
    logic          ram_wen_q, ram_wen_d;
    logic [AW-1:0] ram_raddr_q, ram_raddr_d;
    logic          ram_ren_q, ram_ren_d;
    logic          pick_dbus;

`ifdef SERVING_ARB_RR_EN
    logic last_dbus_q, last_dbus_d;
`endif

    logic unused_adr_lsbs;
    assign unused_adr_lsbs = ^{i_ibus_adr[1:0], i_dbus_adr[1:0]};

`ifdef SERVING_ARB_RR_EN
    assign pick_dbus = i_dbus_cyc && (!i_ibus_cyc || !last_dbus_q);
`else
    assign pick_dbus = i_dbus_cyc;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        adr_d      = adr_q;
        dat_d      = dat_q;
        sel_d      = sel_q;
        gnt_dbus_d = gnt_dbus_q;
        ibus_rdt_d = ibus_rdt_q;
        dbus_rdt_d = dbus_rdt_q;
`ifdef SERVING_ARB_RR_EN
        last_dbus_d = last_dbus_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (i_dbus_cyc || i_ibus_cyc) begin
                    gnt_dbus_d = pick_dbus;
                    adr_d      = pick_dbus ? i_dbus_adr[AW-1:2] : i_ibus_adr[AW-1:2];
                    dat_d      = i_dbus_dat;
                    sel_d      = pick_dbus ? i_dbus_sel : 4'h0;
                    cnt_d      = 2'd0;
                    state_d    = (pick_dbus && i_dbus_we) ? S_WR : S_RD_ISSUE;
`ifdef SERVING_ARB_RR_EN
                    last_dbus_d = pick_dbus;
`endif
                end
            end
            S_WR: begin
                if (cnt_q == 2'd3) state_d = S_DONE;
                else               cnt_d   = cnt_q + 2'd1;
            end
            S_RD_ISSUE: state_d = S_RD_WAIT;
            S_RD_WAIT: begin
                if (i_ram_ack) begin
                    if (gnt_dbus_q) dbus_rdt_d[{cnt_q, 3'b000} +: 8] = i_ram_rdata;
                    else            ibus_rdt_d[{cnt_q, 3'b000} +: 8] = i_ram_rdata;
                    if (cnt_q == 2'd3) begin
                        state_d = S_DONE;
                    end else begin
                        cnt_d   = cnt_q + 2'd1;
                        state_d = S_RD_ISSUE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Outputs are decoded from the next state so the registered strobes line up with their state.
        ram_waddr_d = {adr_d, cnt_d};
        ram_raddr_d = {adr_d, cnt_d};
        ram_wdata_d = dat_d[{cnt_d, 3'b000} +: 8];
        ram_wen_d   = (state_d == S_WR) && sel_d[cnt_d];
        ram_ren_d   = (state_d == S_RD_ISSUE);
        ibus_ack_d  = (state_d == S_DONE) && !gnt_dbus_d;
        dbus_ack_d  = (state_d == S_DONE) && gnt_dbus_d;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= 2'd0;
            adr_q       <= '0;
            dat_q       <= '0;
            sel_q       <= '0;
            gnt_dbus_q  <= 1'b0;
            ibus_rdt_q  <= '0;
            dbus_rdt_q  <= '0;
            ibus_ack_q  <= 1'b0;
            dbus_ack_q  <= 1'b0;
            ram_waddr_q <= '0;
            ram_wdata_q <= '0;
            ram_wen_q   <= 1'b0;
            ram_raddr_q <= '0;
            ram_ren_q   <= 1'b0;
`ifdef SERVING_ARB_RR_EN
            last_dbus_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            sel_q       <= sel_d;
            gnt_dbus_q  <= gnt_dbus_d;
            ibus_rdt_q  <= ibus_rdt_d;
            dbus_rdt_q  <= dbus_rdt_d;
            ibus_ack_q  <= ibus_ack_d;
            dbus_ack_q  <= dbus_ack_d;
            ram_waddr_q <= ram_waddr_d;
            ram_wdata_q <= ram_wdata_d;
            ram_wen_q   <= ram_wen_d;
            ram_raddr_q <= ram_raddr_d;
            ram_ren_q   <= ram_ren_d;
`ifdef SERVING_ARB_RR_EN
            last_dbus_q <= last_dbus_d;
`endif
        end
    end

    assign o_ibus_rdt  = ibus_rdt_q;
    assign o_ibus_ack  = ibus_ack_q;
    assign o_dbus_rdt  = dbus_rdt_q;
    assign o_dbus_ack  = dbus_ack_q;
    assign o_ram_waddr = ram_waddr_q;
    assign o_ram_wdata = ram_wdata_q;
    assign o_ram_wen   = ram_wen_q;
    assign o_ram_raddr = ram_raddr_q;
    assign o_ram_ren   = ram_ren_q;

endmodule

// File: tb/tb_serving_ram_arbiter.sv
// tb/tb_serving_ram_arbiter.sv - directed self-checking bench for serving_ram_arbiter
module tb_serving_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  ibus_adr = '0;
    logic        ibus_cyc = 1'b0;
    logic [31:0] ibus_rdt;
    logic        ibus_ack;
    logic [7:0]  dbus_adr = '0;
    logic [31:0] dbus_dat = '0;
    logic [3:0]  dbus_sel = '0;
    logic        dbus_we = 1'b0;
    logic        dbus_cyc = 1'b0;
    logic [31:0] dbus_rdt;
    logic        dbus_ack;
    logic [7:0]  ram_waddr;
    logic [7:0]  ram_wdata;
    logic        ram_wen;
    logic [7:0]  ram_raddr;
    logic        ram_ren;
    logic [7:0]  ram_rdata = '0;
    logic        ram_ack = 1'b0;

    logic [7:0]  mem [256];
    int          checks = 0;
    int          errors = 0;
    int          wen_cnt, ren_cnt, both_cnt, iack_cnt, dack_cnt;

    serving_ram_arbiter #(.DEPTH(256)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_ibus_adr  (ibus_adr),
        .i_ibus_cyc  (ibus_cyc),
        .o_ibus_rdt  (ibus_rdt),
        .o_ibus_ack  (ibus_ack),
        .i_dbus_adr  (dbus_adr),
        .i_dbus_dat  (dbus_dat),
        .i_dbus_sel  (dbus_sel),
        .i_dbus_we   (dbus_we),
        .i_dbus_cyc  (dbus_cyc),
        .o_dbus_rdt  (dbus_rdt),
        .o_dbus_ack  (dbus_ack),
        .o_ram_waddr (ram_waddr),
        .o_ram_wdata (ram_wdata),
        .o_ram_wen   (ram_wen),
        .o_ram_raddr (ram_raddr),
        .o_ram_ren   (ram_ren),
        .i_ram_rdata (ram_rdata),
        .i_ram_ack   (ram_ack)
    );

    always #5 clk = ~clk;

    // Byte RAM with one-cycle read latency.
    always @(posedge clk) begin
        if (ram_wen) mem[ram_waddr] <= ram_wdata;
        ram_ack <= ram_ren;
        if (ram_ren) ram_rdata <= mem[ram_raddr];
    end

    always @(negedge clk) begin
        if (ram_wen) wen_cnt = wen_cnt + 1;
        if (ram_ren) ren_cnt = ren_cnt + 1;
        if (ram_wen && ram_ren) both_cnt = both_cnt + 1;
        if (ibus_ack) iack_cnt = iack_cnt + 1;
        if (dbus_ack) dack_cnt = dack_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic clear_counts();
        wen_cnt = 0; ren_cnt = 0; both_cnt = 0; iack_cnt = 0; dack_cnt = 0;
    endtask

    task automatic run_txn(input logic is_d, input logic [7:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input logic we, input int drop_at,
                           output int lat, output logic [31:0] rdt);
        int   n;
        logic got;
        clear_counts();
        if (is_d) begin
            dbus_adr = adr; dbus_dat = dat; dbus_sel = sel; dbus_we = we; dbus_cyc = 1'b1;
        end else begin
            ibus_adr = adr; ibus_cyc = 1'b1;
        end
        n = 1; got = 1'b0; lat = 0; rdt = '0;
        while (!got && n < 60) begin
            @(posedge clk); #1;
            n = n + 1;
            if (n == drop_at) begin dbus_cyc = 1'b0; ibus_cyc = 1'b0; end
            if (is_d ? dbus_ack : ibus_ack) begin
                got = 1'b1; lat = n; rdt = is_d ? dbus_rdt : ibus_rdt;
            end
        end
        dbus_cyc = 1'b0; ibus_cyc = 1'b0;
        if (!got) check("ack_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

    initial begin
        int          lat;
        logic [31:0] rdt;
        logic [3:0]  seq;
        logic [3:0]  exp_seq;
        int          k, budget;

        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        clear_counts();

        // 1: reset with random inputs
        for (int i = 0; i < 4; i++) begin
            ibus_adr = 8'($urandom); ibus_cyc = 1'($urandom);
            dbus_adr = 8'($urandom); dbus_dat = $urandom; dbus_sel = 4'($urandom);
            dbus_we = 1'($urandom); dbus_cyc = 1'($urandom);
            @(posedge clk); #1;
        end
        check("rst_ibus_rdt", ibus_rdt, 32'h0);
        check("rst_dbus_rdt", dbus_rdt, 32'h0);
        check("rst_acks", {30'd0, ibus_ack, dbus_ack}, 32'h0);
        check("rst_ram_w", {15'd0, ram_wen, ram_waddr, ram_wdata}, 32'h0);
        check("rst_ram_r", {23'd0, ram_ren, ram_raddr}, 32'h0);
        ibus_cyc = 1'b0; dbus_cyc = 1'b0;
        ibus_adr = '0; dbus_adr = '0; dbus_dat = '0; dbus_sel = '0; dbus_we = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        clear_counts();
        repeat (3) @(posedge clk);
        #1;
        check("idle_strobes", wen_cnt + ren_cnt + iack_cnt + dack_cnt, 32'd0);

        // 2: full-word write
        run_txn(1'b1, 8'h10, 32'hDEADBEEF, 4'hF, 1'b1, 0, lat, rdt);
        check("wr_latency", lat, 32'd6);
        check("wr_wen_cnt", wen_cnt, 32'd4);
        check("wr_ack_cnt", dack_cnt, 32'd1);
        check("wr_mem", {mem[8'h13], mem[8'h12], mem[8'h11], mem[8'h10]}, 32'hDEADBEEF);

        // 3: partial write, address low bits ignored
        run_txn(1'b1, 8'h12, 32'h11223344, 4'b0101, 1'b1, 0, lat, rdt);
        check("pwr_wen_cnt", wen_cnt, 32'd2);
        check("pwr_mem", {mem[8'h13], mem[8'h12], mem[8'h11], mem[8'h10]}, 32'hDE22BE44);

        // 4: ibus read
        run_txn(1'b0, 8'h10, 32'h0, 4'h0, 1'b0, 0, lat, rdt);
        check("rd_latency", lat, 32'd10);
        check("rd_rdt", rdt, 32'hDE22BE44);
        check("rd_ren_cnt", ren_cnt, 32'd4);
        check("rd_wen_cnt", wen_cnt, 32'd0);
        check("rd_iack_cnt", iack_cnt, 32'd1);
        check("rd_dbus_quiet", {31'd0, dbus_ack} | dack_cnt, 32'd0);
        check("rd_dbus_rdt", dbus_rdt, 32'h0);

        // cyc dropped mid-transaction still completes
        run_txn(1'b1, 8'h11, 32'h0, 4'h0, 1'b0, 3, lat, rdt);
        check("drop_rdt", rdt, 32'hDE22BE44);
        check("drop_ack_cnt", dack_cnt, 32'd1);
        check("ibus_rdt_hold", ibus_rdt, 32'hDE22BE44);

        // 5: contention over four grants
        clear_counts();
        ibus_adr = 8'h10; dbus_adr = 8'h10; dbus_we = 1'b0;
        ibus_cyc = 1'b1; dbus_cyc = 1'b1;
        seq = '0; k = 0; budget = 0;
        while (k < 4 && budget < 200) begin
            @(posedge clk); #1;
            budget = budget + 1;
            if (dbus_ack || ibus_ack) begin
                seq = {seq[2:0], dbus_ack};
                k = k + 1;
            end
        end
        ibus_cyc = 1'b0; dbus_cyc = 1'b0;
`ifdef SERVING_ARB_RR_EN
        exp_seq = 4'b1010;
`else
        exp_seq = 4'b1111;
`endif
        check("arb_count", k, 32'd4);
        check("arb_order", {28'd0, seq}, {28'd0, exp_seq});
        check("arb_both_strobes", both_cnt, 32'd0);
        repeat (3) @(posedge clk);
        #1;

        // 6: reset during the third write byte
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        clear_counts();
        dbus_adr = 8'h10; dbus_dat = 32'hDEADBEEF; dbus_sel = 4'hF; dbus_we = 1'b1; dbus_cyc = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("pre_rst_waddr", {23'd0, ram_wen, ram_waddr}, {23'd0, 1'b1, 8'h12});
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_strobes", {30'd0, ram_wen, ram_ren}, 32'h0);
        check("mid_rst_wr", {16'd0, ram_waddr, ram_wdata}, 32'h0);
        dbus_cyc = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("mid_rst_mem", {mem[8'h13], mem[8'h12], mem[8'h11], mem[8'h10]}, 32'h0000BEEF);
        check("mid_rst_no_ack", dack_cnt + iack_cnt, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
